st7789_spi_sink: RTL
====================

Name: st7789_spi_sink

Overview:
- Display-side decoder for the 4-wire SPI stream that drives the ST7789 LCD: spi_clk, spi_mosi, spi_dc and spi_resn.
- Oversamples the SPI lines in its own clock domain and assembles bytes.
- Interprets CASET (0x2A), RASET (0x2B) and RAMWR (0x2C), and emits one pixel write per received 16-bit colour, with its x/y address.
- Used as a loopback checker in simulation and on-board, and as the front end of a framebuffer capture.

Parameters:
- c_x_bits, 8, width of pixel_x and of the internal column address.
- c_y_bits, 8, width of pixel_y and of the internal row address.
- c_color_bits, 16, pixel width. Only 16 (RGB565, 2 bytes per pixel, MSB byte first) is legal; any other value is an elaboration error.

Ports:
- clk  in  1  system clock; must be at least 4x the spi_clk frequency.
- reset  in  1  synchronous, active-high reset.
- spi_clk  in  1  SPI clock, mode 3: idles high, data sampled on rising edge.
- spi_mosi  in  1  serial data, MSB first.
- spi_dc  in  1  0 = command byte, 1 = parameter/data byte; sampled with bit 0 of each byte.
- spi_resn  in  1  display reset, active low.
- byte_valid  out  1  one-cycle strobe: a byte completed.
- byte_data  out  8  last completed byte.
- byte_dc  out  1  dc value of the last completed byte.
- pixel_valid  out  1  one-cycle strobe: a pixel was written.
- pixel_x  out  c_x_bits  column of the pixel.
- pixel_y  out  c_y_bits  row of the pixel.
- pixel_color  out  c_color_bits  RGB565 value of the pixel.

Behaviour:
Clock and reset
- Single clock clk. Reset is synchronous and active-high.
- Reset values: all outputs 0; bit counter 0; state IDLE.
- Window registers reset to the full window: xs=0, xe=all ones, ys=0, ye=all ones. The address counters x,y also reset to 0.

Input sampling and edge detection
- spi_clk, spi_mosi, spi_dc and spi_resn each pass through a 2-FF synchroniser.
- A rising edge is detected as: synchronised spi_clk = 1 and its previous value = 0.

Display reset
- While synchronised spi_resn = 0, the block behaves as if reset were asserted, except byte_*/pixel_* strobes are simply held 0. This is the only byte-alignment mechanism; there is no chip select.

Byte assembly
- On each detected rising edge, shift mosi into the shift register LSB-side and increment the 3-bit bit counter. The counter wraps 7->0.
- When the 8th bit arrives:
  - byte_data is loaded with the full byte and byte_dc with the synchronised dc.
  - byte_valid is pulsed for 1 cycle.
  - This happens on the clk cycle after the edge is detected.
- Latency: a byte's byte_valid is high 4 clk cycles after its 8th spi_clk rising edge reaches the input (2 sync + 1 detect + 1 register).

Decoder state machine (acts only on byte_valid)
- A command byte (dc=0) is accepted in any state and aborts any partial parameter sequence or pending pixel half:
  - 0x2A -> CASET, parameter index 0.
  - 0x2B -> RASET, parameter index 0.
  - 0x2C -> RAMWR; x<=xs, y<=ys, high-byte flag cleared.
  - Any other command -> IDLE.
- CASET: 4 data bytes are XS[15:8], XS[7:0], XE[15:8], XE[7:0]. After the 4th byte, xs/xe take the low c_x_bits bits and the state goes to IDLE. Further data bytes in IDLE are ignored.
- RASET: same as CASET, applied to ys/ye.
- RAMWR:
  - Even data bytes are latched as the colour high byte.
  - Odd data bytes complete the pixel. The following cycle, pixel_valid=1 with pixel_x=x, pixel_y=y, pixel_color={hi,lo}. So pixel_valid is 1 clk after the byte_valid of the low byte.
  - After each pixel: if x==xe then x<=xs and y<=(y==ye ? ys : y+1); else x<=x+1.
  - Data bytes in IDLE are ignored.
- Window edge cases:
  - xs>xe: x counts up to all ones and wraps to 0 before matching xe. The same rule applies to y.
  - Values wider than c_x_bits/c_y_bits are truncated silently.

Simultaneous events
- reset dominates spi_resn, which dominates all SPI activity.
- A byte_valid coincident with a pixel_valid cycle is processed normally. The decoder never stalls, and there is no back-pressure.

Test Plan:
- Reset then send cmd 0x2C and data 0xF8,0x00,0x07,0xE0 -> two pixel_valid pulses: (0,0,0xF800) then (1,0,0x07E0); each 1 clk after byte_valid of its low byte.
- CASET 0x00,0x0A,0x00,0x0B; RASET 0x00,0x05,0x00,0x06; RAMWR with 5 pixels -> coordinates (10,5) (11,5) (10,6) (11,6) (10,5).
- During RAMWR send 3 data bytes and then cmd 0x00 -> only one pixel_valid; the pending high byte is discarded; later data bytes produce no pixels.
- Pull spi_resn low after 3 bits of a byte, release, then send a byte 0xA5 -> byte_data=0xA5, i.e. alignment restored.
- Set clk=4x spi_clk, measure from the 8th rising spi_clk edge -> byte_valid exactly 4 clk later.
- Assert reset mid-RAMWR -> all outputs 0 next cycle; a subsequent RAMWR starts at (0,0) with the full window.

Source files
------------

// File: rtl/st7789_spi_sink.sv
// ST7789 4-wire SPI sink: oversamples the bus, assembles bytes and decodes
// CASET/RASET/RAMWR into addressed RGB565 pixel writes.
module st7789_spi_sink #(
  parameter int c_x_bits     = 8,
  parameter int c_y_bits     = 8,
  parameter int c_color_bits = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    spi_clk,
  input  logic                    spi_mosi,
  input  logic                    spi_dc,
  input  logic                    spi_resn,
  output logic                    byte_valid,
  output logic [7:0]              byte_data,
  output logic                    byte_dc,
  output logic                    pixel_valid,
  output logic [c_x_bits-1:0]     pixel_x,
  output logic [c_y_bits-1:0]     pixel_y,
  output logic [c_color_bits-1:0] pixel_color
);

  if (c_color_bits != 16) begin : g_bad_color
    $error("st7789_spi_sink: c_color_bits must be 16 (RGB565)");
  end

  typedef enum logic [1:0] {S_IDLE, S_CASET, S_RASET, S_RAMWR} state_t;

  logic [1:0] r_sclk, r_smosi, r_sdc, r_sresn;
  logic       r_sclk_d;
  logic       w_rst;

  // Synchronisers run through display reset so no false edge appears on release.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sclk   <= 2'b11;
      r_sclk_d <= 1'b1;
      r_smosi  <= 2'b00;
      r_sdc    <= 2'b00;
      r_sresn  <= 2'b11;
    end else begin
      r_sclk   <= {r_sclk[0], spi_clk};
      r_sclk_d <= r_sclk[1];
      r_smosi  <= {r_smosi[0], spi_mosi};
      r_sdc    <= {r_sdc[0], spi_dc};
      r_sresn  <= {r_sresn[0], spi_resn};
    end
  end

  assign w_rst = reset | ~r_sresn[1];

  logic       r_rise, r_mosi_d, r_dc_d;
  logic [6:0] r_sr;
  logic [2:0] r_bcnt;

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_rise     <= 1'b0;
      r_mosi_d   <= 1'b0;
      r_dc_d     <= 1'b0;
      r_sr       <= '0;
      r_bcnt     <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      byte_dc    <= 1'b0;
    end else begin
      r_rise     <= r_sclk[1] & ~r_sclk_d;
      r_mosi_d   <= r_smosi[1];
      r_dc_d     <= r_sdc[1];
      byte_valid <= 1'b0;
      if (r_rise) begin
        r_sr   <= {r_sr[5:0], r_mosi_d};
        r_bcnt <= r_bcnt + 3'd1;
        if (r_bcnt == 3'd7) begin
          byte_valid <= 1'b1;
          byte_data  <= {r_sr, r_mosi_d};
          byte_dc    <= r_dc_d;
        end
      end
    end
  end

  state_t              r_state, w_state_nxt;
  logic [1:0]          r_pidx;
  logic [7:0]          r_phi;
  logic [15:0]         r_pstart;
  logic [7:0]          r_hi;
  logic                r_hi_vld;
  logic [c_x_bits-1:0] r_xs, r_xe, r_x;
  logic [c_y_bits-1:0] r_ys, r_ye, r_y;

  always_ff @(posedge clk) begin
    if (w_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (byte_valid) begin
      if (!byte_dc) begin
        case (byte_data)
          8'h2A:   w_state_nxt = S_CASET;
          8'h2B:   w_state_nxt = S_RASET;
          8'h2C:   w_state_nxt = S_RAMWR;
          default: w_state_nxt = S_IDLE;
        endcase
      end else if ((r_state == S_CASET || r_state == S_RASET) && r_pidx == 2'd3) begin
        w_state_nxt = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_pidx      <= '0;
      r_phi       <= '0;
      r_pstart    <= '0;
      r_hi        <= '0;
      r_hi_vld    <= 1'b0;
      r_xs        <= '0;
      r_xe        <= '1;
      r_ys        <= '0;
      r_ye        <= '1;
      r_x         <= '0;
      r_y         <= '0;
      pixel_valid <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      pixel_color <= '0;
    end else begin
      pixel_valid <= 1'b0;
      if (byte_valid) begin
        if (!byte_dc) begin
          // Any command drops partial parameters and a pending colour high byte.
          r_pidx   <= '0;
          r_hi_vld <= 1'b0;
          if (byte_data == 8'h2C) begin
            r_x <= r_xs;
            r_y <= r_ys;
          end
        end else begin
          case (r_state)
            S_CASET, S_RASET: begin
              r_pidx <= r_pidx + 2'd1;
              r_phi  <= byte_data;
              if (r_pidx == 2'd1) r_pstart <= {r_phi, byte_data};
              if (r_pidx == 2'd3) begin
                if (r_state == S_CASET) begin
                  r_xs <= c_x_bits'(r_pstart);
                  r_xe <= c_x_bits'({r_phi, byte_data});
                end else begin
                  r_ys <= c_y_bits'(r_pstart);
                  r_ye <= c_y_bits'({r_phi, byte_data});
                end
              end
            end
            S_RAMWR: begin
              if (!r_hi_vld) begin
                r_hi     <= byte_data;
                r_hi_vld <= 1'b1;
              end else begin
                r_hi_vld    <= 1'b0;
                pixel_valid <= 1'b1;
                pixel_x     <= r_x;
                pixel_y     <= r_y;
                pixel_color <= {r_hi, byte_data};
                // Plain increment wraps through all ones when xs > xe.
                if (r_x == r_xe) begin
                  r_x <= r_xs;
                  r_y <= (r_y == r_ye) ? r_ys : r_y + c_y_bits'(1);
                end else begin
                  r_x <= r_x + c_x_bits'(1);
                end
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule
